vga_pixel_fetch: RTL

//  Pixel fetch stage between the VGA timing generator (h/v counts + syncs) and the RGB pins.

---
 rtl/vga_pixel_fetch.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: maps the 640x480 raster onto a centred grayscale image, reads the
// result memory and lines the returned pixels up with delayed syncs; one frame per start.
module vga_pixel_fetch #(
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter int         IMG_W    = 256,
  parameter int         IMG_H    = 256,
  parameter int         X0       = 192,
  parameter int         Y0       = 112,
  parameter int         MEM_LAT  = 1,
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] BORDER   = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int L  = MEM_LAT + 2;
  localparam int P  = L - 1;
  localparam int CW = $clog2(L + 1);

  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] X_BEG = 11'(X0);
  localparam logic [10:0] X_END = 11'(X0 + IMG_W);
  localparam logic [10:0] Y_BEG = 11'(Y0);
  localparam logic [10:0] Y_END = 11'(Y0 + IMG_H);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  X0_10  = 10'(X0);
  localparam logic [9:0]  Y0_10  = 10'(Y0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [10:0]       h_ext, v_ext;
  logic              at_origin, at_last;
  logic              act_s, img_s, fetch_s;
  logic [9:0]        x_off, y_off;
  logic [ADDR_W-1:0] addr_next;

  logic [P-1:0] act_p, fetch_p;
  logic [L-1:0] hs_p, vs_p;
  logic [7:0]   gray;

  assign h_ext     = {1'b0, h_count};
  assign v_ext     = {1'b0, v_count};
  assign at_origin = (h_count == 10'd0) && (v_count == 10'd0);
  assign at_last   = (h_count == H_LAST) && (v_count == V_LAST);
  assign act_s     = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign img_s     = act_s && (h_ext >= X_BEG) && (h_ext < X_END)
                           && (v_ext >= Y_BEG) && (v_ext < Y_END);
  // The origin sample that moves ARM to RUN already counts as a RUN sample.
  assign fetch_s   = img_s && ((state_q == RUN) || ((state_q == ARM) && at_origin));
  assign x_off     = h_count - X0_10;
  assign y_off     = v_count - Y0_10;
  assign addr_next = ADDR_W'(32'(y_off) * 32'(IMG_W) + 32'(x_off));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (start) state_d = ARM;
      ARM:   if (at_origin) state_d = RUN;
      RUN: begin
        if (at_last) begin
          state_d = DRAIN;
          cnt_d   = CW'(L - 1);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:  if (start) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage 0 plus the classification pipe that runs alongside the memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      act_p    <= '0;
      fetch_p  <= '0;
    end else begin
      if (img_s) mem_addr <= addr_next;
      act_p   <= {act_p[P-2:0], act_s};
      fetch_p <= {fetch_p[P-2:0], fetch_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p <= '0;
      vs_p <= '0;
    end else begin
      hs_p <= {hs_p[L-2:0], hsync_in};
      vs_p <= {vs_p[L-2:0], vsync_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray <= '0;
    end else if (fetch_p[P-1]) begin
      gray <= mem_data;
    end else if (act_p[P-1] && ((state_q == RUN) || (state_q == DRAIN))) begin
      gray <= BORDER;
    end else begin
      gray <= '0;
    end
  end

  assign mem_rd_en = fetch_p[0];
  assign hsync     = hs_p[L-1];
  assign vsync     = vs_p[L-1];
  assign R         = gray;
  assign G         = gray;
  assign B         = gray;
  assign busy      = (state_q == ARM) || (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign fsm_state = state_q;

endmodule
